// File: rtl/data_memory_pipelined.sv
// Byte-lane data memory with a valid/ready request port and an in-order, stallable response pipeline.
// Handles lane alignment, sign/zero extension and error flagging for misaligned or out-of-range accesses.
module data_memory_pipelined #(
    parameter int unsigned WORD_BYTES   = 4,
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [1:0]                req_size,
    input  logic                      req_unsigned,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [8*WORD_BYTES-1:0]   req_wdata,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [8*WORD_BYTES-1:0]   resp_rdata,
    output logic                      resp_error,
    output logic                      resp_write
);

    localparam int unsigned     DATA_W    = 8 * WORD_BYTES;
    localparam int unsigned     OFF_W     = $clog2(WORD_BYTES);
    localparam int unsigned     IDX_W     = $clog2(DEPTH_WORDS);
    localparam longint unsigned MEM_BYTES = longint'(DEPTH_WORDS) * longint'(WORD_BYTES);

    logic [7:0] mem [WORD_BYTES][DEPTH_WORDS];

    logic              advance;
    logic              accept;
    logic [OFF_W-1:0]  rq_off;
    logic [IDX_W-1:0]  rq_idx;
    logic              rq_misaligned;
    logic              rq_out_of_range;
    logic              rq_error;
    logic [WORD_BYTES-1:0] be_size;
    logic [WORD_BYTES-1:0] rq_be;
    logic [DATA_W-1:0] rq_wdata;
    logic [DATA_W-1:0] rd_word;

    // Whole pipeline moves together unless a held response blocks the last stage.
    assign advance   = !resp_valid || resp_ready;
    assign req_ready = advance;
    assign accept    = req_valid && advance;

    // Request decode: word index, lane mask, aligned store data, error flags.
    always_comb begin
        rq_off          = req_addr[OFF_W-1:0];
        rq_idx          = req_addr[OFF_W +: IDX_W];
        rq_misaligned   = 1'b0;
        be_size         = '1;
        case (req_size)
            2'd0: begin
                rq_misaligned = 1'b0;
                be_size       = WORD_BYTES'(1);
            end
            2'd1: begin
                rq_misaligned = req_addr[0];
                be_size       = WORD_BYTES'(3);
            end
            2'd2: begin
                rq_misaligned = |req_addr[1:0];
                be_size       = WORD_BYTES'(15);
            end
            default: begin
                rq_misaligned = (WORD_BYTES == 4) || (|req_addr[2:0]);
                be_size       = '1;
            end
        endcase
        rq_out_of_range = 64'(req_addr) >= MEM_BYTES;
        rq_error        = rq_misaligned || rq_out_of_range;
        rq_be           = be_size << rq_off;
        rq_wdata        = req_wdata << {rq_off, 3'b000};
        for (int unsigned l = 0; l < WORD_BYTES; l++) begin
            rd_word[8*l +: 8] = mem[l][rq_idx];
        end
    end

    // Stores land at the accept edge; errored stores are dropped.
    always_ff @(posedge clock) begin
        if (accept && req_write && !rq_error) begin
            for (int unsigned l = 0; l < WORD_BYTES; l++) begin
                if (rq_be[l]) begin
                    mem[l][rq_idx] <= rq_wdata[8*l +: 8];
                end
            end
        end
    end

    function automatic logic [DATA_W-1:0] extract(
        input logic [DATA_W-1:0] raw,
        input logic [OFF_W-1:0]  off,
        input logic [1:0]        size,
        input logic              uns
    );
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] mask;
        logic [DATA_W-1:0] msb;
        sh   = raw >> {off, 3'b000};
        mask = (DATA_W'(1) << (32'd8 << size)) - DATA_W'(1);
        if (size == 2'd3) begin
            mask = '1;
        end
        msb     = mask ^ (mask >> 1);
        extract = sh & mask;
        if (!uns && (|(sh & msb))) begin
            extract = extract | ~mask;
        end
    endfunction

    logic              fin_valid;
    logic              fin_write;
    logic              fin_error;
    logic              fin_unsigned;
    logic [1:0]        fin_size;
    logic [OFF_W-1:0]  fin_off;
    logic [DATA_W-1:0] fin_raw;

    if (READ_LATENCY == 2) begin : g_lat2
        logic              s0_valid;
        logic              s0_write;
        logic              s0_error;
        logic              s0_unsigned;
        logic [1:0]        s0_size;
        logic [OFF_W-1:0]  s0_off;
        logic [DATA_W-1:0] s0_raw;

        // Extra stage between the array read and the response register.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                s0_valid    <= 1'b0;
                s0_write    <= 1'b0;
                s0_error    <= 1'b0;
                s0_unsigned <= 1'b0;
                s0_size     <= '0;
                s0_off      <= '0;
                s0_raw      <= '0;
            end else if (advance) begin
                s0_valid    <= req_valid;
                s0_write    <= req_write;
                s0_error    <= rq_error;
                s0_unsigned <= req_unsigned;
                s0_size     <= req_size;
                s0_off      <= rq_off;
                s0_raw      <= rd_word;
            end
        end

        assign fin_valid    = s0_valid;
        assign fin_write    = s0_write;
        assign fin_error    = s0_error;
        assign fin_unsigned = s0_unsigned;
        assign fin_size     = s0_size;
        assign fin_off      = s0_off;
        assign fin_raw      = s0_raw;
    end else begin : g_lat1
        assign fin_valid    = req_valid;
        assign fin_write    = req_write;
        assign fin_error    = rq_error;
        assign fin_unsigned = req_unsigned;
        assign fin_size     = req_size;
        assign fin_off      = rq_off;
        assign fin_raw      = rd_word;
    end

    // Final stage holds the already-extracted response so every resp_* is a flop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
            resp_write <= 1'b0;
        end else if (advance) begin
            resp_valid <= fin_valid;
            resp_write <= fin_valid && fin_write;
            resp_error <= fin_valid && fin_error;
            resp_rdata <= (fin_valid && !fin_write && !fin_error)
                          ? extract(fin_raw, fin_off, fin_size, fin_unsigned) : '0;
        end
    end

endmodule

// File: tb/tb_data_memory_pipelined.sv
// Randomised and directed bench for data_memory_pipelined: a 4-byte/latency-1 and an 8-byte/latency-2 instance
// checked every cycle against a byte-addressed reference memory and an expected-response queue.
module tb_data_memory_pipelined;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        logic        wr;
        int          cyc;
        int          stalls;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        req_valid    [2];
    logic        req_write    [2];
    logic [1:0]  req_size     [2];
    logic        req_unsigned [2];
    logic [31:0] req_addr     [2];
    logic [63:0] req_wdata    [2];
    logic        resp_ready   [2];
    wire  [1:0]  req_ready_v;
    wire  [1:0]  resp_valid_v;
    wire  [1:0]  resp_error_v;
    wire  [1:0]  resp_write_v;
    wire  [31:0] rdata_a;
    wire  [63:0] rdata_b;

    exp_t        sbq [2][$];
    logic [7:0]  mmem [2][8192];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          pop_cnt [2];
    int          stalls [2];
    logic        held [2];
    logic [63:0] held_rd [2];
    logic [1:0]  held_ew [2];
    logic [63:0] last_rdata [2];
    logic        last_err [2];

    data_memory_pipelined #(
        .WORD_BYTES(4), .DEPTH_WORDS(1024), .ADDR_W(32), .READ_LATENCY(1)
    ) u_a (
        .clock(clock), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready_v[0]), .req_write(req_write[0]),
        .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0][31:0]),
        .resp_valid(resp_valid_v[0]), .resp_ready(resp_ready[0]), .resp_rdata(rdata_a),
        .resp_error(resp_error_v[0]), .resp_write(resp_write_v[0])
    );

    data_memory_pipelined #(
        .WORD_BYTES(8), .DEPTH_WORDS(1024), .ADDR_W(32), .READ_LATENCY(2)
    ) u_b (
        .clock(clock), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready_v[1]), .req_write(req_write[1]),
        .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid_v[1]), .resp_ready(resp_ready[1]), .resp_rdata(rdata_b),
        .resp_error(resp_error_v[1]), .resp_write(resp_write_v[1])
    );

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [63:0] get_rdata(input int i);
        return (i == 1) ? rdata_b : {32'b0, rdata_a};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // Reference: byte-addressed memory, little-endian, errors from alignment/range rules.
    task automatic model_accept(input int i);
        exp_t        e;
        int          wb;
        int          n;
        longint      a;
        logic [63:0] v;
        logic [63:0] m;
        wb = (i == 1) ? 8 : 4;
        n  = 1 << req_size[i];
        a  = longint'(req_addr[i]);
        e.wr     = req_write[i];
        e.err    = (n == 8 && wb == 4) || (a % n != 0) || (a >= 1024 * wb);
        e.rdata  = 64'd0;
        e.cyc    = cyc;
        e.stalls = stalls[i];
        if (!e.err) begin
            if (req_write[i]) begin
                for (int b = 0; b < n; b++) mmem[i][int'(a) + b] = req_wdata[i][8*b +: 8];
            end else begin
                v = 64'd0;
                for (int b = 0; b < n; b++) v = v | (64'(mmem[i][int'(a) + b]) << (8 * b));
                m = (n == 8) ? {64{1'b1}} : ((64'd1 << (8 * n)) - 64'd1);
                if (!req_unsigned[i] && ((v >> (8 * n - 1)) & 64'd1) == 64'd1) v = v | ~m;
                if (wb == 4) v = v & 64'h0000_0000_FFFF_FFFF;
                e.rdata = v;
            end
        end
        sbq[i].push_back(e);
    endtask

    // Per-cycle compare: handshake rule, held-response stability, in-order data and exact latency.
    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                sbq[i].delete();
                held[i] = 1'b0;
            end else begin
                logic        rv;
                logic        rr;
                logic [63:0] rd;
                exp_t        e;
                rv = resp_valid_v[i];
                rr = resp_ready[i];
                rd = get_rdata(i);
                chk($sformatf("u%0d req_ready", i), 64'(req_ready_v[i]), 64'(!(rv && !rr)));
                if (held[i]) begin
                    chk($sformatf("u%0d held valid", i), 64'(rv), 64'd1);
                    chk($sformatf("u%0d held rdata", i), rd, held_rd[i]);
                    chk($sformatf("u%0d held err/wr", i), 64'({resp_error_v[i], resp_write_v[i]}), 64'(held_ew[i]));
                end
                if (rv && rr) begin
                    if (sbq[i].size() == 0) begin
                        chk($sformatf("u%0d unexpected response", i), 64'(sbq[i].size()), 64'd1);
                    end else begin
                        e = sbq[i].pop_front();
                        chk($sformatf("u%0d rdata", i), rd, e.rdata);
                        chk($sformatf("u%0d error", i), 64'(resp_error_v[i]), 64'(e.err));
                        chk($sformatf("u%0d write", i), 64'(resp_write_v[i]), 64'(e.wr));
                        chk($sformatf("u%0d latency", i), 64'(cyc),
                            64'(e.cyc + i + 1 + stalls[i] - e.stalls));
                        pop_cnt[i]++;
                        last_rdata[i] = rd;
                        last_err[i]   = resp_error_v[i];
                    end
                end
                held[i] = rv && !rr;
                if (held[i]) begin
                    held_rd[i] = rd;
                    held_ew[i] = {resp_error_v[i], resp_write_v[i]};
                    stalls[i]++;
                end
                if (req_valid[i] && req_ready_v[i]) model_accept(i);
            end
        end
    end

    task automatic issue(input int i, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [63:0] wd);
        logic ok;
        ok = 1'b0;
        @(posedge clock); #1;
        req_valid[i]    = 1'b1;
        req_write[i]    = wr;
        req_size[i]     = sz;
        req_unsigned[i] = uns;
        req_addr[i]     = a;
        req_wdata[i]    = wd;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clock); #2;
            if (req_ready_v[i]) ok = 1'b1;
            else begin @(posedge clock); #1; end
        end
        if (!ok) chk($sformatf("u%0d accept timeout", i), 64'(ok), 64'd1);
    endtask

    task automatic idle(input int i);
        @(posedge clock); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic directed(input int i, input string name, input logic wr, input logic [1:0] sz,
                            input logic uns, input logic [31:0] a, input logic [63:0] wd,
                            input logic [63:0] exp_rd, input logic exp_err);
        int start;
        start = pop_cnt[i];
        issue(i, wr, sz, uns, a, wd);
        idle(i);
        for (int k = 0; k < 20 && pop_cnt[i] == start; k++) begin
            @(negedge clock); #2;
        end
        chk({name, " response seen"}, 64'(pop_cnt[i] > start), 64'd1);
        chk({name, " rdata"}, last_rdata[i], exp_rd);
        chk({name, " error"}, 64'(last_err[i]), 64'(exp_err));
    endtask

    task automatic run_random(input int i, input int ncyc);
        int unsigned sz;
        int unsigned a;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clock); #1;
            sz = $urandom_range(0, 3);
            a  = $urandom_range(0, 511);
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            if ($urandom_range(0, 15) == 0) a = a + ((i == 1) ? 8192 : 4096);
            if ($urandom_range(0, 63) == 0) a = $urandom;
            req_valid[i]    = ($urandom_range(0, 4) != 0);
            req_write[i]    = $urandom_range(0, 1) == 1;
            req_size[i]     = 2'(sz);
            req_unsigned[i] = $urandom_range(0, 1) == 1;
            req_addr[i]     = a;
            req_wdata[i]    = {$urandom, $urandom};
            resp_ready[i]   = ($urandom_range(0, 3) != 0);
        end
        @(posedge clock); #1;
        req_valid[i]  = 1'b0;
        resp_ready[i] = 1'b1;
        repeat (10) @(posedge clock);
        #1 chk($sformatf("u%0d queue drained", i), 64'(sbq[i].size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   start;
        int   k;
        logic seen_low;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_write[i] = 1'b0; req_size[i] = 2'd0; req_unsigned[i] = 1'b0;
            req_addr[i] = 32'd0; req_wdata[i] = 64'd0; resp_ready[i] = 1'b1;
            pop_cnt[i] = 0; stalls[i] = 0; held[i] = 1'b0; last_rdata[i] = 64'd0; last_err[i] = 1'b0;
        end

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset resp_valid", 64'(resp_valid_v), 64'd0);
        chk("reset rdata a", 64'(rdata_a), 64'd0);
        chk("reset rdata b", rdata_b, 64'd0);
        chk("reset err/wr", 64'({resp_error_v, resp_write_v}), 64'd0);
        @(posedge clock); #1 reset = 1'b0;
        #1 chk("req_ready after reset", 64'(req_ready_v), 64'd3);

        // Fill the region the random phase touches so every load has defined data.
        for (int a = 0; a < 512; a += 4) issue(0, 1'b1, 2'd2, 1'b0, 32'(a), {$urandom, $urandom});
        idle(0);
        for (int a = 0; a < 512; a += 8) issue(1, 1'b1, 2'd3, 1'b0, 32'(a), {$urandom, $urandom});
        idle(1);
        repeat (4) @(posedge clock);

        directed(0, "st w 0x10",  1'b1, 2'd2, 1'b0, 32'h10, 64'hDEADBEEF, 64'd0, 1'b0);
        directed(0, "ld bu 0x11", 1'b0, 2'd0, 1'b1, 32'h11, 64'd0, 64'h0000_00BE, 1'b0);
        directed(0, "ld bs 0x13", 1'b0, 2'd0, 1'b0, 32'h13, 64'd0, 64'hFFFF_FFDE, 1'b0);
        directed(0, "st w 0x20",  1'b1, 2'd2, 1'b0, 32'h20, 64'd0, 64'd0, 1'b0);
        directed(0, "st h 0x22",  1'b1, 2'd1, 1'b0, 32'h22, 64'h8001, 64'd0, 1'b0);
        directed(0, "ld w 0x20",  1'b0, 2'd2, 1'b0, 32'h20, 64'd0, 64'h8001_0000, 1'b0);
        directed(0, "ld hs 0x22", 1'b0, 2'd1, 1'b0, 32'h22, 64'd0, 64'hFFFF_8001, 1'b0);
        directed(0, "ld h 0x23",  1'b0, 2'd1, 1'b0, 32'h23, 64'd0, 64'd0, 1'b1);
        directed(0, "st w 0x04",  1'b1, 2'd2, 1'b0, 32'h04, 64'h55, 64'd0, 1'b0);
        directed(0, "st w 0x06",  1'b1, 2'd2, 1'b0, 32'h06, 64'h1234_5678, 64'd0, 1'b1);
        directed(0, "ld w 0x04",  1'b0, 2'd2, 1'b0, 32'h04, 64'd0, 64'h55, 1'b0);
        directed(0, "ld w 0x1000", 1'b0, 2'd2, 1'b0, 32'h1000, 64'd0, 64'd0, 1'b1);
        directed(0, "st d on w4", 1'b1, 2'd3, 1'b0, 32'h08, 64'd1, 64'd0, 1'b1);

        directed(1, "st d 0x8",   1'b1, 2'd3, 1'b0, 32'h8, 64'h0123_4567_89AB_CDEF, 64'd0, 1'b0);
        directed(1, "ld ws 0xC",  1'b0, 2'd2, 1'b0, 32'hC, 64'd0, 64'h0000_0000_0123_4567, 1'b0);
        directed(1, "ld ws 0x8",  1'b0, 2'd2, 1'b0, 32'h8, 64'd0, 64'hFFFF_FFFF_89AB_CDEF, 1'b0);
        directed(1, "ld bu 0xF",  1'b0, 2'd0, 1'b1, 32'hF, 64'd0, 64'h01, 1'b0);
        directed(1, "ld d 0x4",   1'b0, 2'd3, 1'b0, 32'h4, 64'd0, 64'd0, 1'b1);

        // Four back-to-back loads, consumer stalls from the second response onward.
        start = pop_cnt[1];
        k = 0;
        seen_low = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clock); #1;
            resp_ready[1]   = !((pop_cnt[1] - start >= 1) && c < 12);
            req_valid[1]    = (k < 4);
            req_write[1]    = 1'b0;
            req_size[1]     = 2'd2;
            req_unsigned[1] = 1'b0;
            req_addr[1]     = 32'(8 + 4 * k);
            @(negedge clock); #2;
            if (!req_ready_v[1]) seen_low = 1'b1;
            if (req_valid[1] && req_ready_v[1]) k++;
        end
        chk("bp req_ready fell", 64'(seen_low), 64'd1);
        chk("bp loads accepted", 64'(k), 64'd4);
        chk("bp responses", 64'(pop_cnt[1] - start), 64'd4);

        // Reset with two loads in flight on the latency-2 instance.
        resp_ready[1] = 1'b1;
        issue(1, 1'b0, 2'd2, 1'b0, 32'h8, 64'd0);
        issue(1, 1'b0, 2'd3, 1'b0, 32'h8, 64'd0);
        @(posedge clock); #1;
        req_valid[1] = 1'b0;
        chk("pre-reset resp_valid", 64'(resp_valid_v[1]), 64'd1);
        reset = 1'b1;
        #1;
        chk("reset drops resp_valid", 64'(resp_valid_v[1]), 64'd0);
        chk("reset clears rdata", rdata_b, 64'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        #1 chk("req_ready after reset 2", 64'(req_ready_v[1]), 64'd1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clock); #2;
            chk("no stale response", 64'(resp_valid_v[1]), 64'd0);
        end
        directed(1, "retain ld 0xC", 1'b0, 2'd2, 1'b1, 32'hC, 64'd0, 64'h0123_4567, 1'b0);

        run_random(0, 1500);
        run_random(1, 1500);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_memory_pipelined.md
Name: data_memory_pipelined

Overview:
- Parametrised successor to the stage-4 byte-lane data memory.
- Accepts load/store requests over a valid/ready handshake.
- Generates byte enables internally from size and address. Performs lane alignment plus sign/zero extension, and flags misaligned or out-of-range accesses.
- Returns one in-order response per request through a stallable pipeline of configurable read latency.

Parameters:
- WORD_BYTES, 4, bytes per memory word; legal values 4 or 8; DATA_W = 8*WORD_BYTES.
- DEPTH_WORDS, 1024, number of words; power of two.
- ADDR_W, 32, byte-address width.
- READ_LATENCY, 1, cycles from request accept to resp_valid; legal values 1 or 2.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears pipeline state, not memory contents
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when req_valid && req_ready
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word (32b), 3 = dword (64b, WORD_BYTES=8 only)
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-justified (LSBs)
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response when resp_valid && resp_ready
- resp_rdata  out  DATA_W  load result, extended to DATA_W; 0 for stores and errors
- resp_error  out  1  access was misaligned or out of range
- resp_write  out  1  echo of req_write for this response

Behaviour:
- Storage: WORD_BYTES byte-lane arrays of DEPTH_WORDS entries.
  - Word index = req_addr[log2(WORD_BYTES) +: log2(DEPTH_WORDS)].
  - Lane 0 holds the lowest byte address (little-endian).
- Byte enables: size-wide mask shifted left by addr[log2(WORD_BYTES)-1:0]. Store data is shifted into the same lanes.
- Error conditions (any of these):
  - size 1 with addr[0] != 0;
  - size 2 with addr[1:0] != 0;
  - size 3 with addr[2:0] != 0;
  - size 3 when WORD_BYTES = 4;
  - addr >= DEPTH_WORDS*WORD_BYTES.
  - Errored stores write nothing. Errored loads return rdata 0. Both still produce a response with resp_error = 1.
- Pipeline: READ_LATENCY stages of {valid, write, error, size, unsigned, lane offset, raw word}. The memory array is read at the accept edge.
- Advance: the whole pipeline advances when the final stage is empty or resp_ready = 1.
  - req_ready = advance.
  - Holding resp_valid with resp_ready = 0 freezes every stage and holds all resp_* outputs stable.
- Latency: a request accepted at edge N produces resp_valid high after edge N+READ_LATENCY-1 (visible in cycle N+READ_LATENCY), absent back-pressure.
- Stores: memory is updated at the accept edge. A load accepted on any later edge sees the new data; no forwarding is required.
- Extraction: the final stage shifts the raw word right by 8*offset and masks to the access size. It then sign- or zero-extends to DATA_W.
- Throughput: one request per cycle when resp_ready is held at 1. Responses return strictly in request order.
- Reset (asynchronous):
  - All stage valids are cleared, so resp_valid = 0.
  - resp_rdata = 0, resp_error = 0, resp_write = 0.
  - req_ready = 1 in the first cycle after reset deasserts.
  - Memory contents are unchanged.
  - A store accepted on the same edge reset asserts is not guaranteed to be written. In-flight loads are dropped without a response.
- The handshake ignores req_* when req_valid = 0; memory is never written.

Test Plan:
- WORD_BYTES=4, LAT=1: store word 0xDEADBEEF at 0x10, then load byte unsigned at 0x11 -> rdata 0x000000BE, error 0. Load byte signed at 0x13 -> 0xFFFFFFDE.
- Store half 0x8001 at 0x22, then load word at 0x20 with memory preset 0 -> rdata 0x80010000. Load half signed at 0x22 -> 0xFFFF8001.
- Load half at 0x23 -> resp_error 1, rdata 0. Store word at 0x06 -> error 1 and word 1 unchanged on readback. Address 0x1000 with DEPTH 1024 -> error 1.
- LAT=2 back-to-back: 4 loads at consecutive cycles with resp_ready held 0 from the second response onward -> req_ready falls, the held response stays stable, and after release all 4 responses arrive in order with no loss or duplication.
- WORD_BYTES=8: store dword 0x0123456789ABCDEF at 0x8, then load word signed at 0xC -> 0x0000000001234567. Load size 3 at 0x4 -> error 1.
- Assert reset with 2 loads in flight (LAT=2) -> resp_valid drops immediately; after release req_ready = 1, no stale response appears, and memory retains prior stores.
